// File: rtl/rhythm_pkg.sv
// Shared definitions for the rhythm-game blocks: keyboard codes, round states
// and the score width used by the droppers and the scoreboard.
package rhythm_pkg;

    localparam logic [7:0] KEY_START = 8'h2C;
    localparam logic [7:0] KEY_ABORT = 8'h01;
    localparam int         SCORE_W   = 14;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/bin2bcd14.sv
// Combinational double-dabble: 14-bit binary to four packed BCD digits.
// Values above 9999 lose their ten-thousands digit.
module bin2bcd14
    import rhythm_pkg::*;
(
    input  logic [SCORE_W-1:0] bin_i,
    output logic [15:0]        bcd_o
);

    logic [15:0] bcd;

    always_comb begin
        bcd = '0;
        for (int i = SCORE_W - 1; i >= 0; i--) begin
            // Add-3 on any digit >= 5 before it is doubled by the shift.
            for (int d = 0; d < 4; d++) begin
                if (bcd[4*d +: 4] > 4'd4) begin
                    bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
                end
            end
            bcd = {bcd[14:0], bin_i[i]};
        end
    end

    assign bcd_o = bcd;

endmodule

// File: rtl/score_tally.sv
// Scoreboard: counts new rising dropper hit flags during a round, keeps a
// saturating score and combo, and exposes BCD score plus round status to the HUD.
module score_tally
    import rhythm_pkg::*;
#(
    parameter int N_LANES       = 32,
    parameter int SONG_FRAMES   = 2400,
    parameter int COMBO_TIMEOUT = 120,
    parameter int SCORE_MAX     = 9999
) (
    input  logic               frame_clk,
    input  logic               Reset,
    input  logic [7:0]         keycode,
    input  logic [7:0]         keycode_second,
    input  logic [N_LANES-1:0] score_vec,
    output logic [SCORE_W-1:0] score_bin,
    output logic [15:0]        score_bcd,
    output logic [7:0]         combo,
    output logic [7:0]         max_combo,
    output logic               hit_pulse,
    output logic               game_over
);

    localparam int NW = $clog2(N_LANES + 1);
    localparam int FW = $clog2(SONG_FRAMES + 1);
    localparam int IW = $clog2(COMBO_TIMEOUT + 1);

    function automatic logic [NW-1:0] popcount(input logic [N_LANES-1:0] v);
        logic [NW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < N_LANES; i++) begin
            cnt = cnt + NW'(v[i]);
        end
        return cnt;
    endfunction

    state_e             state_q;
    logic [N_LANES-1:0] score_q;
    logic [FW-1:0]      frame_q;
    logic [IW-1:0]      idle_q;
    logic [SCORE_W-1:0] score_bin_q;
    logic [15:0]        score_bcd_q;
    logic [7:0]         combo_q;
    logic [7:0]         max_combo_q;
    logic               hit_pulse_q;
    logic               game_over_q;

    logic               key_abort;
    logic               key_start;
    logic [NW-1:0]      n_hits;
    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W-1:0] score_bin_d;
    logic [8:0]         combo_sum;
    logic [7:0]         combo_d;
    logic [7:0]         max_combo_d;
    logic [IW-1:0]      idle_d;
    logic [15:0]        bcd_w;

    assign key_abort = (keycode == KEY_ABORT) || (keycode_second == KEY_ABORT);
    assign key_start = (keycode == KEY_START) || (keycode_second == KEY_START);

    always_comb begin
        n_hits      = popcount(score_vec & ~score_q);
        score_sum   = {1'b0, score_bin_q} + (SCORE_W + 1)'(n_hits);
        score_bin_d = (score_sum > (SCORE_W + 1)'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX)
                                                              : score_sum[SCORE_W-1:0];
        combo_sum   = {1'b0, combo_q} + 9'(n_hits);
        combo_d     = combo_q;
        idle_d      = idle_q;
        if (n_hits != '0) begin
            combo_d = combo_sum[8] ? 8'hFF : combo_sum[7:0];
            idle_d  = '0;
        end else if (idle_q == IW'(COMBO_TIMEOUT - 1)) begin
            combo_d = 8'd0;
            idle_d  = '0;
        end else begin
            idle_d  = idle_q + 1'b1;
        end
        max_combo_d = (combo_d > max_combo_q) ? combo_d : max_combo_q;
    end

    bin2bcd14 u_bcd (
        .bin_i (score_bin_q),
        .bcd_o (bcd_w)
    );

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            score_q     <= '0;
            frame_q     <= '0;
            idle_q      <= '0;
            score_bin_q <= '0;
            score_bcd_q <= '0;
            combo_q     <= '0;
            max_combo_q <= '0;
            hit_pulse_q <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            score_q     <= score_vec;
            score_bcd_q <= bcd_w;
            hit_pulse_q <= 1'b0;
            // Abort wins over start, and leaving a round clears it on the same edge.
            if (state_q == IDLE || key_abort) begin
                state_q     <= (key_start && !key_abort) ? PLAY : IDLE;
                frame_q     <= '0;
                idle_q      <= '0;
                score_bin_q <= '0;
                combo_q     <= '0;
                max_combo_q <= '0;
                game_over_q <= 1'b0;
            end else if (state_q == PLAY) begin
                score_bin_q <= score_bin_d;
                combo_q     <= combo_d;
                max_combo_q <= max_combo_d;
                idle_q      <= idle_d;
                hit_pulse_q <= (n_hits != '0);
                if (frame_q == FW'(SONG_FRAMES - 1)) begin
                    state_q     <= DONE;
                    game_over_q <= 1'b1;
                end else begin
                    frame_q <= frame_q + 1'b1;
                end
            end
        end
    end

    assign score_bin = score_bin_q;
    assign score_bcd = score_bcd_q;
    assign combo     = combo_q;
    assign max_combo = max_combo_q;
    assign hit_pulse = hit_pulse_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_score_tally.sv
// Randomised bench for score_tally: a frame-level reference model of the round
// rules is compared with every output after every frame edge.
module tb_score_tally;

    localparam int N_LANES       = 32;
    localparam int SONG_FRAMES   = 2400;
    localparam int COMBO_TIMEOUT = 120;
    localparam int SCORE_MAX     = 9999;

    localparam int S_IDLE = 0;
    localparam int S_PLAY = 1;
    localparam int S_DONE = 2;

    logic        frame_clk;
    logic        Reset;
    logic [7:0]  keycode;
    logic [7:0]  keycode_second;
    logic [31:0] score_vec;
    logic [13:0] score_bin;
    logic [15:0] score_bcd;
    logic [7:0]  combo;
    logic [7:0]  max_combo;
    logic        hit_pulse;
    logic        game_over;

    score_tally #(
        .N_LANES       (N_LANES),
        .SONG_FRAMES   (SONG_FRAMES),
        .COMBO_TIMEOUT (COMBO_TIMEOUT),
        .SCORE_MAX     (SCORE_MAX)
    ) dut (
        .frame_clk      (frame_clk),
        .Reset          (Reset),
        .keycode        (keycode),
        .keycode_second (keycode_second),
        .score_vec      (score_vec),
        .score_bin      (score_bin),
        .score_bcd      (score_bcd),
        .combo          (combo),
        .max_combo      (max_combo),
        .hit_pulse      (hit_pulse),
        .game_over      (game_over)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s got %0d (0x%0h) want %0d (0x%0h)", tag, actual, actual, expected, expected);
        end
    endtask

    // Reference model: round state and tallies as plain integers.
    int          m_state;
    logic [31:0] m_prev;
    int          m_score, m_combo, m_max, m_frames, m_hitless, m_hit, m_over, m_bcd;

    function automatic int to_bcd(input int v);
        return (((v / 1000) % 10) << 12) | (((v / 100) % 10) << 8) |
               (((v / 10) % 10) << 4) | (v % 10);
    endfunction

    task automatic model_reset();
        m_state = S_IDLE; m_prev = '0;
        m_score = 0; m_combo = 0; m_max = 0; m_frames = 0; m_hitless = 0;
        m_hit = 0; m_over = 0; m_bcd = 0;
    endtask

    task automatic model_clear_round();
        m_score = 0; m_combo = 0; m_max = 0; m_frames = 0; m_hitless = 0; m_over = 0;
    endtask

    task automatic model_edge(input logic [7:0] k1, input logic [7:0] k2, input logic [31:0] v);
        bit abort_k, start_k;
        int n;
        abort_k = (k1 == 8'h01) || (k2 == 8'h01);
        start_k = (k1 == 8'h2C) || (k2 == 8'h2C);
        n       = $countones(v & ~m_prev);
        m_prev  = v;
        m_bcd   = to_bcd(m_score);
        m_hit   = 0;
        case (m_state)
            S_IDLE: begin
                model_clear_round();
                if (start_k && !abort_k) m_state = S_PLAY;
            end
            S_PLAY: begin
                if (abort_k) begin
                    model_clear_round();
                    m_state = S_IDLE;
                end else begin
                    m_score = (m_score + n > SCORE_MAX) ? SCORE_MAX : m_score + n;
                    if (n > 0) begin
                        m_combo   = (m_combo + n > 255) ? 255 : m_combo + n;
                        m_hitless = 0;
                    end else begin
                        m_hitless++;
                        if (m_hitless == COMBO_TIMEOUT) begin
                            m_combo   = 0;
                            m_hitless = 0;
                        end
                    end
                    if (m_combo > m_max) m_max = m_combo;
                    m_hit = (n > 0);
                    m_frames++;
                    if (m_frames == SONG_FRAMES) begin
                        m_state = S_DONE;
                        m_over  = 1;
                    end
                end
            end
            default: begin
                if (abort_k) begin
                    model_clear_round();
                    m_state = S_IDLE;
                end
            end
        endcase
    endtask

    task automatic compare_all();
        check("score_bin", 32'(score_bin), 32'(m_score));
        check("score_bcd", 32'(score_bcd), 32'(m_bcd));
        check("combo",     32'(combo),     32'(m_combo));
        check("max_combo", 32'(max_combo), 32'(m_max));
        check("hit_pulse", 32'(hit_pulse), 32'(m_hit));
        check("game_over", 32'(game_over), 32'(m_over));
    endtask

    // Called at a falling edge: drive, take the rising edge, check, return at the next falling edge.
    task automatic step(input logic [7:0] k1, input logic [7:0] k2, input logic [31:0] v);
        keycode        = k1;
        keycode_second = k2;
        score_vec      = v;
        @(posedge frame_clk);
        model_edge(k1, k2, v);
        #1;
        compare_all();
        @(negedge frame_clk);
    endtask

    initial begin
        int pulses;
        int rem;
        int guard;
        logic [31:0] v;
        logic [7:0]  k;

        Reset = 1'b1; keycode = '0; keycode_second = '0; score_vec = '0;
        model_reset();
        #12;
        compare_all();
        @(negedge frame_clk);
        Reset = 1'b0;
        step(8'h00, 8'h00, 32'h0);

        // Single hit held for ten frames
        step(8'h2C, 8'h00, 32'h0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step(8'h00, 8'h00, 32'h0000_0008);
            if (hit_pulse) pulses++;
            if (i == 0) begin
                check("single_score", 32'(score_bin), 32'd1);
                check("single_combo", 32'(combo), 32'd1);
                check("single_pulse", 32'(hit_pulse), 32'd1);
            end
            if (i == 1) check("single_bcd", 32'(score_bcd), 32'h0001);
        end
        check("single_pulse_frames", 32'(pulses), 32'd1);

        // Abort clears; abort beats start on the same frame
        step(8'h01, 8'h00, 32'h0);
        check("abort_clear", 32'(score_bin), 32'd0);
        step(8'h2C, 8'h01, 32'h0);
        step(8'h00, 8'h00, 32'h0000_00FF);
        check("abort_priority_score", 32'(score_bin), 32'd0);
        check("abort_priority_pulse", 32'(hit_pulse), 32'd0);
        step(8'h00, 8'h00, 32'h0);

        // Simultaneous hits, then combo timeout
        step(8'h2C, 8'h00, 32'h0);
        step(8'h00, 8'h00, 32'h8000_0021);
        check("simul_score", 32'(score_bin), 32'd3);
        check("simul_combo", 32'(combo), 32'd3);
        check("simul_max",   32'(max_combo), 32'd3);
        step(8'h00, 8'h00, 32'h0);
        step(8'h00, 8'h00, 32'h0000_0008);
        check("combo4", 32'(combo), 32'd4);
        for (int i = 1; i <= COMBO_TIMEOUT; i++) begin
            step(8'h00, 8'h00, 32'h0000_0008);
            if (i == COMBO_TIMEOUT - 1) check("timeout_edge_minus1", 32'(combo), 32'd4);
            if (i == COMBO_TIMEOUT) begin
                check("timeout_combo", 32'(combo), 32'd0);
                check("timeout_max",   32'(max_combo), 32'd4);
            end
        end

        // Random play with sparse hits and harmless keycodes
        for (int i = 0; i < 300; i++) begin
            k = 8'($urandom_range(2, 255));
            v = $urandom & $urandom;
            if ($urandom_range(0, 3) == 0) v = 32'h0;
            step(k, 8'($urandom_range(2, 255)), v);
        end

        // Preload score to 9998, then saturate
        step(8'h00, 8'h00, 32'h0);
        guard = 0;
        while (m_score < 9998 && guard < 1500) begin
            rem = 9998 - m_score;
            v = (rem >= 32) ? 32'hFFFF_FFFF : ((32'd1 << rem) - 32'd1);
            step(8'h00, 8'h00, v);
            step(8'h00, 8'h00, 32'h0);
            guard++;
        end
        check("preload_9998", 32'(score_bin), 32'd9998);
        step(8'h00, 8'h00, 32'h0000_001F);
        check("saturate", 32'(score_bin), 32'd9999);
        step(8'h00, 8'h00, 32'h0000_001F);
        check("saturate_bcd", 32'(score_bcd), 32'h9999);

        // Run out the song
        for (int i = 0; i < SONG_FRAMES && m_state != S_DONE; i++) begin
            step(8'h00, 8'h00, 32'h0);
        end
        check("game_over", 32'(game_over), 32'd1);
        step(8'h00, 8'h00, 32'h0);
        step(8'h00, 8'h00, 32'h0000_00FF);
        check("done_frozen", 32'(score_bin), 32'd9999);
        check("done_no_pulse", 32'(hit_pulse), 32'd0);
        step(8'h01, 8'h00, 32'h0);
        check("done_exit_score", 32'(score_bin), 32'd0);
        check("done_exit_over",  32'(game_over), 32'd0);
        step(8'h00, 8'h00, 32'h0);

        // Asynchronous reset mid-round at score 57
        step(8'h2C, 8'h00, 32'h0);
        step(8'h00, 8'h00, 32'hFFFF_FFFF);
        step(8'h00, 8'h00, 32'h0);
        step(8'h00, 8'h00, 32'h01FF_FFFF);
        check("pre_reset_57", 32'(score_bin), 32'd57);
        #1;
        Reset = 1'b1;
        model_reset();
        #1;
        check("rst_score_bin", 32'(score_bin), 32'd0);
        check("rst_score_bcd", 32'(score_bcd), 32'd0);
        check("rst_combo",     32'(combo), 32'd0);
        check("rst_max_combo", 32'(max_combo), 32'd0);
        check("rst_hit_pulse", 32'(hit_pulse), 32'd0);
        check("rst_game_over", 32'(game_over), 32'd0);
        @(negedge frame_clk);
        Reset = 1'b0;
        step(8'h00, 8'h00, 32'h0000_00F0);
        check("post_reset_idle", 32'(score_bin), 32'd0);
        step(8'h00, 8'h00, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
